lfsr_seed_ctrl: RTL and testbench

- Control stage directly upstream and downstream of lfsr64. Drives seed/manualSeed into lfsr64, lets it free-run for a fixed number of shifts, then captures the 64-bit result as a board pattern.
- Offers the captured pattern to the game/board logic over a valid/ready handshake.
- Takes a raw start push-button, synchronises and debounces it, and sequences the LFSR.

---
 rtl/lfsr_seed_ctrl.sv | 145 ++++++++++++++
 tb/tb_lfsr_seed_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seed_ctrl.sv
// Seeds and sequences an external lfsr64, captures its state after a fixed number
// of shifts, and offers the result as a board pattern over a valid/ready handshake.
module lfsr_seed_ctrl #(
    parameter int WIDTH      = 64,
    parameter int RUN_CYCLES = 16,
    parameter int DB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             use_manual,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic [WIDTH-1:0] seed,
    output logic             manualSeed,
    output logic [WIDTH-1:0] grid,
    output logic             grid_valid,
    input  logic             grid_ready,
    output logic             busy
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPT,
        OFFER
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [WIDTH-1:0] seed_n, grid_n;
    logic             grid_valid_n;

    logic            sync1, sync2;
    logic            db_level, db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            start_evt;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as the hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= start_btn;
            sync2 <= sync1;
        end
    end

    // The level only moves after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sync2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign start_evt = db_level & ~db_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            seed       <= '0;
            grid       <= '0;
            grid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            seed       <= seed_n;
            grid       <= grid_n;
            grid_valid <= grid_valid_n;
        end
    end

    // NOTE: every signal driven here gets a hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        count_n      = count;
        seed_n       = seed;
        grid_n       = grid;
        grid_valid_n = grid_valid;
        unique case (state)
            IDLE: begin
                if (start_evt) begin
                    count_n = RUN_LAST;
                    if (use_manual) begin
                        seed_n  = seed_in;
                        state_n = LOAD;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            LOAD: begin
                count_n = RUN_LAST;
                state_n = RUN;
            end
            RUN: begin
                if (count == '0) begin
                    state_n = CAPT;
                end else begin
                    count_n = count - CNT_W'(1);
                end
            end
            CAPT: begin
                grid_n       = lfsr_q;
                grid_valid_n = 1'b1;
                state_n      = OFFER;
            end
            OFFER: begin
                if (grid_ready) begin
                    grid_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign manualSeed = (state == LOAD);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lfsr_seed_ctrl.sv
// Bench for lfsr_seed_ctrl: an lfsr64 stand-in, a timeline-level reference model
// compared every cycle, directed scenarios with literal expectations, and random traffic.
module tb_lfsr_seed_ctrl;

    localparam int W  = 64;
    localparam int R  = 2;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_btn = 1'b0;
    logic         use_manual = 1'b0;
    logic         grid_ready = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [W-1:0] seed, grid;
    logic         manualSeed, grid_valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] lfsr_step(input logic [63:0] v);
        return {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
    endfunction

    function automatic logic [63:0] lfsr_run(input logic [63:0] v, input int n);
        logic [63:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    // lfsr64 stand-in: free-running, no reset, loads seed while manualSeed is high
    logic [63:0] lfsr_env = 64'h0123_4567_89ab_cdef;
    always @(posedge clk) lfsr_env <= manualSeed ? seed : lfsr_step(lfsr_env);

    lfsr_seed_ctrl #(.WIDTH(W), .RUN_CYCLES(R), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .use_manual(use_manual),
        .seed_in(seed_in), .lfsr_q(lfsr_env), .seed(seed), .manualSeed(manualSeed),
        .grid(grid), .grid_valid(grid_valid), .grid_ready(grid_ready), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: button as a delayed sample window, sequence as a timeline
    bit          model_live = 1'b0;
    logic        raw_q[$];
    logic        sync_hist[$];
    bit          m_db, m_start, m_busy, m_valid, m_manual, start_now, flip;
    logic        sync_now;
    int          m_k, m_cap_k;
    logic [63:0] m_seed, m_grid;

    always @(posedge clk) begin
        if (reset) begin
            model_live = 1'b1;
            raw_q = '{1'b0, 1'b0};
            sync_hist.delete();
            m_db = 1'b0; m_start = 1'b0;
            m_busy = 1'b0; m_valid = 1'b0; m_manual = 1'b0;
            m_k = 0; m_cap_k = 0; m_seed = '0; m_grid = '0;
        end else begin
            start_now = m_start;
            sync_now = raw_q.pop_front();
            raw_q.push_back(start_btn);
            sync_hist.push_back(sync_now);
            if (sync_hist.size() > DB) void'(sync_hist.pop_front());
            flip = (sync_hist.size() == DB);
            foreach (sync_hist[i]) if (sync_hist[i] == m_db) flip = 1'b0;
            if (flip) begin
                m_db = !m_db;
                sync_hist.delete();
            end
            m_start = flip && m_db;

            if (!m_busy) begin
                if (start_now) begin
                    m_busy = 1'b1;
                    m_k = 1;
                    m_manual = use_manual;
                    if (use_manual) m_seed = seed_in;
                    m_cap_k = (use_manual ? 1 : 0) + R + 1;
                end
            end else if (m_valid) begin
                if (grid_ready) begin
                    m_valid = 1'b0;
                    m_busy = 1'b0;
                end
            end else if (m_k == m_cap_k) begin
                m_grid = m_manual ? lfsr_run(m_seed, R) : lfsr_env;
                m_valid = 1'b1;
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("busy", busy, m_busy);
            check("grid_valid", grid_valid, m_valid);
            check("grid", grid, m_grid);
            check("seed", seed, m_seed);
            check("manualSeed", manualSeed, m_busy && m_manual && m_k == 1 && !m_valid);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch(input int n, output int first_busy, output int first_valid,
                         output int ms_cnt, output int episodes);
        logic prev_v;
        first_busy = -1; first_valid = -1; ms_cnt = 0; episodes = 0;
        prev_v = grid_valid;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (busy && first_busy < 0) first_busy = i;
            if (grid_valid && first_valid < 0) first_valid = i;
            if (manualSeed) ms_cnt++;
            if (grid_valid && !prev_v) episodes++;
            prev_v = grid_valid;
        end
    endtask

    task automatic wait_valid(input int budget);
        int waited;
        waited = 0;
        while (!grid_valid && waited < budget) begin
            tick(1);
            waited++;
        end
        if (!grid_valid) check("wait_valid_timeout", grid_valid, 1'b1);
    endtask

    initial begin
        int fb, fv, ms, ep, run_left;
        logic lvl;
        logic [63:0] s;

        // reset held with the button pressed, released together
        start_btn = 1'b1;
        tick(3);
        reset = 1'b0;
        start_btn = 1'b0;
        tick(1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", grid_valid, 1'b0);
        check("rst_manualSeed", manualSeed, 1'b0);
        check("rst_grid", grid, 64'h0);
        check("rst_seed", seed, 64'h0);
        watch(12, fb, fv, ms, ep);
        check("idle_no_start", fb, -1);

        // manual load of zero seed, consumer always ready
        seed_in = '0; use_manual = 1'b1; grid_ready = 1'b1; start_btn = 1'b1;
        watch(30, fb, fv, ms, ep);
        check("man_first_busy", fb, 7);
        check("man_first_valid", fv, 11);
        check("man_load_cycles", ms, 1);
        check("man_episodes", ep, 1);
        check("man_grid", grid, 64'h0000_0000_0000_0003);
        start_btn = 1'b0;
        tick(12);

        // bouncing press
        s = {$urandom, $urandom};
        seed_in = s;
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0; tick(1);
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0; tick(1);
        start_btn = 1'b1;
        watch(40, fb, fv, ms, ep);
        check("bounce_first_busy", fb, 7);
        check("bounce_episodes", ep, 1);
        check("bounce_grid", grid, lfsr_run(s, R));
        start_btn = 1'b0;
        tick(12);

        // backpressure, button held through OFFER
        s = {$urandom, $urandom};
        seed_in = s; grid_ready = 1'b0; start_btn = 1'b1;
        wait_valid(40);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid_held", grid_valid, 1'b1);
            check("bp_grid_held", grid, lfsr_run(s, R));
            tick(1);
        end
        grid_ready = 1'b1;
        tick(1);
        grid_ready = 1'b0;
        check("bp_valid_drop", grid_valid, 1'b0);
        check("bp_idle", busy, 1'b0);
        check("bp_grid_kept", grid, lfsr_run(s, R));
        watch(15, fb, fv, ms, ep);
        check("held_no_retrigger", fb, -1);
        start_btn = 1'b0;
        tick(12);

        // fresh press while busy in OFFER is dropped
        s = {$urandom, $urandom};
        seed_in = s; start_btn = 1'b1;
        wait_valid(40);
        start_btn = 1'b0; tick(8);
        start_btn = 1'b1; tick(10);
        grid_ready = 1'b1;
        watch(30, fb, fv, ms, ep);
        check("busy_press_episodes", ep, 0);
        check("busy_press_no_restart", fb, -1);
        start_btn = 1'b0;
        tick(12);

        // reset in RUN, then rerun the same seed
        s = {$urandom, $urandom};
        seed_in = s; start_btn = 1'b1;
        tick(8);
        check("mid_run_busy", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        check("run_rst_busy", busy, 1'b0);
        check("run_rst_valid", grid_valid, 1'b0);
        check("run_rst_manualSeed", manualSeed, 1'b0);
        reset = 1'b0; start_btn = 1'b0;
        tick(12);
        start_btn = 1'b1;
        watch(30, fb, fv, ms, ep);
        check("rerun_first_valid", fv, 11);
        check("rerun_grid", grid, lfsr_run(s, R));
        start_btn = 1'b0;
        tick(12);

        // reset in OFFER, then rerun the same seed
        grid_ready = 1'b0; start_btn = 1'b1;
        wait_valid(40);
        reset = 1'b1; start_btn = 1'b0;
        tick(1);
        check("offer_rst_busy", busy, 1'b0);
        check("offer_rst_valid", grid_valid, 1'b0);
        check("offer_rst_manualSeed", manualSeed, 1'b0);
        reset = 1'b0;
        tick(12);
        grid_ready = 1'b1; start_btn = 1'b1;
        watch(30, fb, fv, ms, ep);
        check("reoffer_first_valid", fv, 11);
        check("reoffer_grid", grid, lfsr_run(s, R));
        start_btn = 1'b0;
        tick(12);

        // random traffic against the model
        run_left = 0;
        lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                lvl = 1'($urandom % 2);
                run_left = $urandom_range(1, 20);
            end
            start_btn = ($urandom % 16 == 0) ? ~lvl : lvl;
            run_left--;
            use_manual = 1'($urandom % 2);
            seed_in = {$urandom, $urandom};
            grid_ready = ($urandom % 3 != 0);
            reset = ($urandom % 300 == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
